// File: rtl/rtc_text_render_pkg.sv
// Shared glyph codes, edit-field encodings and character-cell geometry for the
// RTC text renderer.
package rtc_text_render_pkg;

  localparam int CHAR_W  = 16;
  localparam int CHAR_H  = 32;
  localparam int STR_LEN = 8;

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_SLASH = 4'd11;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  typedef enum logic [2:0] {
    EDIT_NONE  = 3'd0,
    EDIT_HOUR  = 3'd1,
    EDIT_MIN   = 3'd2,
    EDIT_SEC   = 3'd3,
    EDIT_DAY   = 3'd4,
    EDIT_MONTH = 3'd5,
    EDIT_YEAR  = 3'd6,
    EDIT_RSVD  = 3'd7
  } edit_field_e;

  // Seven-segment style digit shapes, ordered {a,b,c,d,e,f,g}
  function automatic logic [6:0] digit_segments(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/rtc_text_render_if.sv
// Pixel-stream bus between the sync generator / RTC core and the text renderer.
interface rtc_text_render_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [7:0]  hours, minutes, seconds;
  logic [7:0]  day, month, year;
  logic [2:0]  edit_field;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;

  modport master (
    output pixel_x, pixel_y, video_on, hsync_in, vsync_in,
    output hours, minutes, seconds, day, month, year, edit_field,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, hsync_in, vsync_in,
    input  hours, minutes, seconds, day, month, year, edit_field,
    output rgb, hsync_out, vsync_out
  );
endinterface

// File: rtl/rtc_text_render_font_rom_digits.sv
// 8x16 glyph ROM for digits, ':' and '/', one registered row per lookup.
module font_rom_digits
  import rtc_text_render_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] code,
  input  logic [3:0] row,
  output logic [7:0] row_bits
);

  logic [7:0] bits_c;
  logic [6:0] seg;

  // Digits: bars on rows 2/7/13, verticals on cols 1 and 6 (bit 7 = leftmost)
  always_comb begin
    bits_c = 8'h00;
    seg    = digit_segments(code);
    if (code <= 4'd9) begin
      if ((row == 4'd2 && seg[6]) || (row == 4'd7 && seg[0]) || (row == 4'd13 && seg[3]))
        bits_c = bits_c | 8'h7E;
      if (row >= 4'd2 && row <= 4'd7) begin
        if (seg[1]) bits_c = bits_c | 8'h40;
        if (seg[5]) bits_c = bits_c | 8'h02;
      end
      if (row >= 4'd7 && row <= 4'd13) begin
        if (seg[2]) bits_c = bits_c | 8'h40;
        if (seg[4]) bits_c = bits_c | 8'h02;
      end
    end else if (code == GLYPH_COLON) begin
      if (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11)
        bits_c = 8'h18;
    end else if (code == GLYPH_SLASH) begin
      if (row >= 4'd2 && row <= 4'd13)
        bits_c = 8'h02 << ((row - 4'd2) >> 1);
    end
  end

  always_ff @(posedge clk)
    row_bits <= bits_c;

endmodule

// File: rtl/rtc_text_render.sv
// Renders HH:MM:SS and DD/MM/YY as 2x-scaled glyphs over the VGA pixel stream,
// with a 3-clk pipeline, per-frame BCD shadowing and a blinking edit field.
module rtc_text_render
  import rtc_text_render_pkg::*;
#(
  parameter logic [9:0]  TIME_X0      = 10'd256,
  parameter logic [9:0]  TIME_Y0      = 10'd160,
  parameter logic [9:0]  DATE_X0      = 10'd256,
  parameter logic [9:0]  DATE_Y0      = 10'd240,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] EDIT_COLOR   = 12'hFF0,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic           clk,
  input  logic           reset,
  rtc_text_render_if.slave bus
);

  logic [7:0] sh_hours, sh_minutes, sh_seconds, sh_day, sh_month, sh_year;
  logic       vs_prev, vs_fall, edit_change, blink_on;
  logic [2:0] edit_prev, edit_sel;
  logic [5:0] blink_cnt;

  assign vs_fall     = vs_prev & ~bus.vsync_in;
  assign edit_change = (bus.edit_field != edit_prev);
  assign edit_sel    = (bus.edit_field == 3'(EDIT_RSVD)) ? 3'(EDIT_NONE) : bus.edit_field;

  // Shadows only move on a vsync falling edge; edit changes restart the blink
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sh_hours, sh_minutes, sh_seconds} <= '0;
      {sh_day, sh_month, sh_year}        <= '0;
      vs_prev   <= 1'b1;
      edit_prev <= 3'd0;
      blink_cnt <= 6'd0;
      blink_on  <= 1'b1;
    end else begin
      vs_prev   <= bus.vsync_in;
      edit_prev <= bus.edit_field;
      if (vs_fall) begin
        {sh_hours, sh_minutes, sh_seconds} <= {bus.hours, bus.minutes, bus.seconds};
        {sh_day, sh_month, sh_year}        <= {bus.day, bus.month, bus.year};
      end
      if (edit_change) begin
        blink_cnt <= 6'd0;
        blink_on  <= 1'b1;
      end else if (vs_fall) begin
        if (blink_cnt == 6'(BLINK_FRAMES - 1)) begin
          blink_cnt <= 6'd0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 6'd1;
        end
      end
    end
  end

  // ---- S1: region and character select ----
  logic [9:0] tdx, tdy, ddx, ddy;
  logic [6:1] dx;
  logic [4:1] dy;
  logic       in_time, in_date, edited_c;
  logic [2:0] ci;
  logic [1:0] grp;
  logic [7:0] bcd;
  logic [3:0] nib, code_c;

  assign tdx = bus.pixel_x - TIME_X0;
  assign tdy = bus.pixel_y - TIME_Y0;
  assign ddx = bus.pixel_x - DATE_X0;
  assign ddy = bus.pixel_y - DATE_Y0;
  assign in_time = (bus.pixel_x >= TIME_X0) && (tdx < 10'(STR_LEN * CHAR_W)) &&
                   (bus.pixel_y >= TIME_Y0) && (tdy < 10'(CHAR_H));
  assign in_date = (bus.pixel_x >= DATE_X0) && (ddx < 10'(STR_LEN * CHAR_W)) &&
                   (bus.pixel_y >= DATE_Y0) && (ddy < 10'(CHAR_H));
  assign dx = in_time ? tdx[6:1] : ddx[6:1];
  assign dy = in_time ? tdy[4:1] : ddy[4:1];
  assign ci = dx[6:4];

  always_comb begin
    grp      = 2'd0;
    bcd      = 8'h00;
    nib      = 4'd0;
    code_c   = GLYPH_BLANK;
    edited_c = 1'b0;
    case (ci)
      3'd0, 3'd1, 3'd2: grp = 2'd0;
      3'd3, 3'd4, 3'd5: grp = 2'd1;
      default:          grp = 2'd2;
    endcase
    case (grp)
      2'd0:    bcd = in_time ? sh_hours   : sh_day;
      2'd1:    bcd = in_time ? sh_minutes : sh_month;
      default: bcd = in_time ? sh_seconds : sh_year;
    endcase
    nib = (ci == 3'd0 || ci == 3'd3 || ci == 3'd6) ? bcd[7:4] : bcd[3:0];
    if (in_time || in_date) begin
      if (ci == 3'd2 || ci == 3'd5) begin
        code_c = in_time ? GLYPH_COLON : GLYPH_SLASH;
      end else begin
        code_c   = (nib > 4'd9) ? GLYPH_BLANK : nib;
        edited_c = (edit_sel == ({1'b0, grp} + (in_time ? 3'd1 : 3'd4)));
      end
    end
  end

  logic [3:0] code_p0, row_p0;
  logic [2:0] col_p0, col_p1;
  logic       edited_p0, edited_p1;
  logic       vid_p0, vid_p1, hs_p0, hs_p1, vs_p0, vs_p1;
  logic [7:0] row_bits_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {vid_p0, hs_p0, vs_p0} <= 3'b011;
      {vid_p1, hs_p1, vs_p1} <= 3'b011;
    end else begin
      {vid_p0, hs_p0, vs_p0} <= {bus.video_on, bus.hsync_in, bus.vsync_in};
      {vid_p1, hs_p1, vs_p1} <= {vid_p0, hs_p0, vs_p0};
    end
  end

  always_ff @(posedge clk) begin
    code_p0   <= code_c;
    row_p0    <= dy;
    col_p0    <= dx[3:1];
    edited_p0 <= edited_c;
    col_p1    <= col_p0;
    edited_p1 <= edited_p0;
  end

  // ---- S2: font lookup ----
  font_rom_digits u_font (
    .clk      (clk),
    .code     (code_p0),
    .row      (row_p0),
    .row_bits (row_bits_p1)
  );

  // ---- S3: colour ----
  logic        pix_bit;
  logic [11:0] rgb_c, rgb_q;
  logic        hs_q, vs_q;

  assign pix_bit = row_bits_p1[3'd7 - col_p1];

  always_comb begin
    rgb_c = BG_COLOR;
    if (!vid_p1)
      rgb_c = 12'h000;
    else if (pix_bit && (!edited_p1 || blink_on))
      rgb_c = edited_p1 ? EDIT_COLOR : FG_COLOR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_c;
      hs_q  <= hs_p1;
      vs_q  <= vs_p1;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.hsync_out = hs_q;
  assign bus.vsync_out = vs_q;

endmodule

// File: tb/tb_rtc_text_render.sv
// Bench for rtc_text_render: directed scenarios plus randomized pixels against
// a string-level model of the rendered clock/date text.
module tb_rtc_text_render;

  localparam int          TX0 = 256, TY0 = 160, DX0 = 256, DY0 = 240;
  localparam int          BF  = 2;
  localparam logic [11:0] FG  = 12'hFFF, ED = 12'hFF0, BG = 12'h000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Model state: what the renderer should currently be showing
  int m_sh[6];
  int m_cnt;
  bit m_on;

  string segs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  rtc_text_render_if bus ();

  rtc_text_render #(.BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic bit digit_lit(int d, int col, int row);
    string s = segs[d];
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": if (row == 2  && col >= 1 && col <= 6) return 1;
        "d": if (row == 13 && col >= 1 && col <= 6) return 1;
        "g": if (row == 7  && col >= 1 && col <= 6) return 1;
        "f": if (col == 1 && row >= 2 && row <= 7)  return 1;
        "b": if (col == 6 && row >= 2 && row <= 7)  return 1;
        "e": if (col == 1 && row >= 7 && row <= 13) return 1;
        "c": if (col == 6 && row >= 7 && row <= 13) return 1;
        default: ;
      endcase
    end
    return 0;
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, bit vid);
    int x0, y0, ci, col, row, fld, val, dig, es;
    bit is_time, lit;
    if (!vid) return 12'h000;
    if (x >= TX0 && x < TX0 + 128 && y >= TY0 && y < TY0 + 32) begin
      is_time = 1; x0 = TX0; y0 = TY0;
    end else if (x >= DX0 && x < DX0 + 128 && y >= DY0 && y < DY0 + 32) begin
      is_time = 0; x0 = DX0; y0 = DY0;
    end else return BG;
    ci  = (x - x0) / 16;
    col = ((x - x0) % 16) / 2;
    row = (y - y0) / 2;
    if (ci == 2 || ci == 5) begin
      if (is_time) lit = (row == 4 || row == 5 || row == 10 || row == 11) && (col == 3 || col == 4);
      else         lit = (row >= 2 && row <= 13) && (col == 6 - (row - 2) / 2);
      return lit ? FG : BG;
    end
    fld = ci / 3 + (is_time ? 1 : 4);
    val = m_sh[fld - 1];
    dig = (ci % 3 == 0) ? val / 16 : val % 16;
    if (dig > 9) return BG;
    if (!digit_lit(dig, col, row)) return BG;
    es = (bus.edit_field == 3'd7) ? 0 : int'(bus.edit_field);
    if (fld == es) return m_on ? ED : BG;
    return FG;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic probe(input int x, input int y, input bit vid, output logic [11:0] obs);
    @(negedge clk);
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 10'(y);
    bus.video_on = vid;
    repeat (3) @(posedge clk);
    #1 obs = bus.rgb;
  endtask

  task automatic probe_model(input string tag, input int x, input int y, input bit vid);
    logic [11:0] o;
    probe(x, y, vid, o);
    check(tag, o, model_rgb(x, y, vid));
  endtask

  task automatic frame_with(input logic [2:0] ne);
    @(negedge clk);
    if (ne != bus.edit_field) begin
      m_cnt = 0; m_on = 1;
    end else if (m_cnt == BF - 1) begin
      m_cnt = 0; m_on = !m_on;
    end else m_cnt++;
    m_sh = '{int'(bus.hours), int'(bus.minutes), int'(bus.seconds),
             int'(bus.day), int'(bus.month), int'(bus.year)};
    bus.edit_field = ne;
    bus.vsync_in   = 1'b0;
    @(negedge clk);
    bus.vsync_in   = 1'b1;
  endtask

  task automatic frame();
    frame_with(bus.edit_field);
  endtask

  task automatic set_edit(input logic [2:0] v);
    @(negedge clk);
    if (v != bus.edit_field) begin
      m_cnt = 0; m_on = 1;
    end
    bus.edit_field = v;
    @(posedge clk);
  endtask

  function automatic logic [7:0] rand_bcd();
    return {4'(($urandom % 12)), 4'(($urandom % 12))};
  endfunction

  initial begin
    logic [11:0] o;
    reset = 1'b1;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.video_on = 1'b1;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b1;
    bus.hours = '0; bus.minutes = '0; bus.seconds = '0;
    bus.day = '0; bus.month = '0; bus.year = '0;
    bus.edit_field = '0;
    m_sh = '{0, 0, 0, 0, 0, 0}; m_cnt = 0; m_on = 1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", bus.rgb, 12'h000);
    check("reset_hsync", 12'(bus.hsync_out), 12'h001);
    check("reset_vsync", 12'(bus.vsync_out), 12'h001);
    @(negedge clk);
    reset = 1'b0;
    bus.hsync_in = 1'b1;
    repeat (2) @(posedge clk);

    bus.hours = 8'h12; bus.minutes = 8'h34; bus.seconds = 8'h56;
    bus.day = 8'h31; bus.month = 8'h12; bus.year = 8'h99;
    frame();
    probe(TX0 + 38, TY0 + 8, 1, o); check("colon_lit", o, FG);
    probe(TX0 + 32, TY0 + 8, 1, o); check("colon_dark", o, BG);

    // Latency: pixel and hsync change together, both must land on the 3rd edge
    @(negedge clk);
    bus.pixel_x = 10'(TX0 + 12); bus.pixel_y = 10'(TY0 + 8); bus.hsync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("lat_hsync_2clk", 12'(bus.hsync_out), 12'h001);
    check("lat_rgb_2clk", bus.rgb, BG);
    @(posedge clk);
    #1;
    check("lat_hsync_3clk", 12'(bus.hsync_out), 12'h000);
    check("lat_rgb_3clk", bus.rgb, FG);
    @(negedge clk) bus.hsync_in = 1'b1;

    probe(TX0 + 12, TY0 + 8, 0, o); check("blanking", o, 12'h000);

    bus.minutes = 8'h3A;
    frame();
    probe(TX0 + 66, TY0 + 4, 1, o); check("invalid_bcd_blank", o, BG);
    probe(TX0 + 54, TY0 + 4, 1, o); check("valid_tens_beside", o, FG);
    bus.minutes = 8'h38;
    probe(TX0 + 66, TY0 + 4, 1, o); check("shadow_holds", o, BG);
    frame();
    probe(TX0 + 66, TY0 + 4, 1, o); check("shadow_updates", o, FG);
    bus.minutes = 8'h34;
    frame();

    // Blink on minutes: 2 frames lit, 2 frames dark
    set_edit(3'd2);
    probe(TX0 + 54, TY0 + 4, 1, o); check("blink_f0_min", o, ED);
    probe(TX0 + 12, TY0 + 8, 1, o); check("blink_f0_hour", o, FG);
    frame();
    probe(TX0 + 54, TY0 + 4, 1, o); check("blink_f1_min", o, ED);
    frame();
    probe(TX0 + 54, TY0 + 4, 1, o); check("blink_f2_min", o, BG);
    probe(TX0 + 12, TY0 + 8, 1, o); check("blink_f2_hour", o, FG);
    frame();
    probe(TX0 + 54, TY0 + 4, 1, o); check("blink_f3_min", o, BG);
    frame();
    probe(TX0 + 54, TY0 + 4, 1, o); check("blink_f4_min", o, ED);
    frame();
    frame();
    probe(TX0 + 54, TY0 + 4, 1, o); check("blink_f6_min", o, BG);
    set_edit(3'd3);
    probe(TX0 + 102, TY0 + 4, 1, o); check("restart_sec", o, ED);
    probe(TX0 + 54, TY0 + 4, 1, o); check("restart_min_fg", o, FG);

    // Edit change coincident with a vsync edge: restart wins over the toggle
    frame();
    frame_with(3'd2);
    probe(TX0 + 54, TY0 + 4, 1, o); check("restart_priority", o, ED);
    frame();
    probe(TX0 + 54, TY0 + 4, 1, o); check("restart_prio_f1", o, ED);
    frame();
    probe(TX0 + 54, TY0 + 4, 1, o); check("restart_prio_f2", o, BG);

    for (int blk = 0; blk < 20; blk++) begin
      bus.hours = rand_bcd(); bus.minutes = rand_bcd(); bus.seconds = rand_bcd();
      bus.day = rand_bcd(); bus.month = rand_bcd(); bus.year = rand_bcd();
      case ($urandom % 4)
        0: set_edit(3'($urandom % 8));
        1: frame_with(3'($urandom % 8));
        default: frame();
      endcase
      for (int k = 0; k < 12; k++) begin
        int x, y;
        x = TX0 - 8 + int'($urandom_range(0, 143));
        y = (($urandom % 2) ? TY0 : DY0) - 4 + int'($urandom_range(0, 39));
        probe_model("random_pixel", x, y, ($urandom % 8) != 0);
      end
    end

    // Reset mid-line: outputs drop at once, shadows restart from zero
    set_edit(3'd0);
    probe(TX0 + 38, TY0 + 8, 1, o); check("pre_reset_colon", o, FG);
    @(negedge clk);
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_rgb", bus.rgb, 12'h000);
    check("midreset_hsync", 12'(bus.hsync_out), 12'h001);
    check("midreset_vsync", 12'(bus.vsync_out), 12'h001);
    m_sh = '{0, 0, 0, 0, 0, 0}; m_cnt = 0; m_on = 1;
    bus.pixel_x = 10'(TX0 + 2); bus.pixel_y = 10'(TY0 + 8);
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("post_reset_2clk", bus.rgb, 12'h000);
    @(posedge clk);
    #1 check("post_reset_3clk", bus.rgb, model_rgb(TX0 + 2, TY0 + 8, 1));
    probe(TX0 + 2, TY0 + 8, 1, o); check("post_reset_zero_glyph", o, FG);
    probe_model("post_reset_date", DX0 + 2, DY0 + 8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
